// File: rtl/ps2_text_pkg.sv
// Shared scan-code constants, ASCII bounds and encodings for the PS/2 text path.
package ps2_text_pkg;

    localparam int unsigned SC_W = 8;

    localparam logic [SC_W-1:0] SC_BKSP   = 8'h66;
    localparam logic [SC_W-1:0] SC_ENTER  = 8'h5A;
    localparam logic [SC_W-1:0] SC_ESC    = 8'h76;
    localparam logic [SC_W-1:0] SC_LSHIFT = 8'h12;
    localparam logic [SC_W-1:0] SC_RSHIFT = 8'h59;

    localparam logic [7:0] ASCII_MIN      = 8'h20;
    localparam logic [7:0] ASCII_MAX      = 8'h7E;
    localparam logic [7:0] ASCII_LC_MIN   = 8'h61;
    localparam logic [7:0] ASCII_LC_MAX   = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CHR = 2'd0,
        BS  = 2'd1,
        NL  = 2'd2
    } op_t;

endpackage

// File: rtl/ps2_key_classify.sv
// Combinational classification of a scan code / ASCII pair into an edit op.
module ps2_key_classify
    import ps2_text_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [SC_W-1:0]   i_key_code,
    input  logic [DATA_W-1:0] i_key_ascii,
    output op_t               o_op,
    output logic              o_printable,
    output logic              o_is_esc,
    output logic              o_is_shift
);

    // Special keys take priority; only ordinary keys can be printable.
    always_comb begin
        o_op        = CHR;
        o_is_esc    = (i_key_code == SC_ESC);
        o_is_shift  = (i_key_code == SC_LSHIFT) || (i_key_code == SC_RSHIFT);
        o_printable = 1'b0;
        if (i_key_code == SC_BKSP) begin
            o_op = BS;
        end else if (i_key_code == SC_ENTER) begin
            o_op = NL;
        end else if (!o_is_esc && !o_is_shift) begin
            o_printable = (i_key_ascii >= DATA_W'(ASCII_MIN)) &&
                          (i_key_ascii <= DATA_W'(ASCII_MAX));
        end
    end

endmodule

// File: rtl/ps2_text_buffer_ctrl.sv
// Keystroke-to-character-RAM controller: clear sweep, cursor, BS/Enter/Esc edits.
// Optional build macro PS2_TEXT_SHIFT_EN adds Shift upper-casing of a..z.
module ps2_text_buffer_ctrl
    import ps2_text_pkg::*;
#(
    parameter int unsigned       COLS      = 16,
    parameter int unsigned       ROWS      = 4,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(8'h20),
    localparam int unsigned      ADDR_W    = $clog2(COLS * ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic              key_make,
    input  logic [SC_W-1:0]   key_code,
    input  logic [DATA_W-1:0] key_ascii,
    output logic              we,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy,
    output logic              drop_tick
);

    localparam int unsigned       CELLS     = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] COL_MASK  = ADDR_W'(COLS - 1);

    state_t              r_state, w_state_nxt;
    op_t                 r_op, w_op_nxt;
    logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
    logic [ADDR_W-1:0]   r_cursor, w_cursor_nxt;
    logic                r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic [DATA_W-1:0]   w_char;
    op_t                 w_op;
    logic                w_printable, w_is_esc, w_is_shift;

    ps2_key_classify #(.DATA_W(DATA_W)) u_classify (
        .i_key_code  (key_code),
        .i_key_ascii (key_ascii),
        .o_op        (w_op),
        .o_printable (w_printable),
        .o_is_esc    (w_is_esc),
        .o_is_shift  (w_is_shift)
    );

`ifdef PS2_TEXT_SHIFT_EN
    logic r_shift_held;

    // Track Shift in every state so a release while busy is not lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift_held <= 1'b0;
        end else if (key_valid && w_is_shift) begin
            r_shift_held <= key_make;
        end
    end

    // Upper-case a..z while Shift is held.
    always_comb begin
        w_char = key_ascii;
        if (r_shift_held && (key_ascii >= DATA_W'(ASCII_LC_MIN)) &&
            (key_ascii <= DATA_W'(ASCII_LC_MAX))) begin
            w_char = key_ascii - DATA_W'(ASCII_CASE_OFS);
        end
    end

    assign drop_tick = reset && key_valid && busy && !(w_is_shift && !key_make);
`else
    // Characters go to RAM exactly as mapped.
    always_comb begin
        w_char = key_ascii;
    end

    assign drop_tick = reset && key_valid && busy;
`endif

    assign busy          = (r_state != IDLE);
    assign we            = r_we;
    assign write_address = r_addr;
    assign ram_in        = r_data;
    assign cursor        = r_cursor;

    // Next state plus the RAM port values that belong to the next state.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_idx_nxt    = r_idx;
        w_cursor_nxt = r_cursor;
        w_we_nxt     = 1'b0;
        w_addr_nxt   = '0;
        w_data_nxt   = '0;
        case (r_state)
            CLEAR: begin
                if (!r_we) begin
                    // First sweep cycle after reset: start at cell 0.
                    w_idx_nxt  = '0;
                    w_we_nxt   = 1'b1;
                    w_data_nxt = FILL_CHAR;
                end else if (r_idx == LAST_CELL) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt  = r_idx + ADDR_W'(1);
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = r_idx + ADDR_W'(1);
                    w_data_nxt = FILL_CHAR;
                end
            end
            IDLE: begin
                if (key_valid && key_make) begin
                    if (w_is_esc) begin
                        w_state_nxt  = CLEAR;
                        w_idx_nxt    = '0;
                        w_cursor_nxt = '0;
                        w_we_nxt     = 1'b1;
                        w_data_nxt   = FILL_CHAR;
                    end else if (w_op == BS) begin
                        if (r_cursor != '0) begin
                            w_state_nxt = WRITE;
                            w_op_nxt    = BS;
                            w_we_nxt    = 1'b1;
                            w_addr_nxt  = r_cursor - ADDR_W'(1);
                            w_data_nxt  = FILL_CHAR;
                        end
                    end else if (w_op == NL) begin
                        w_state_nxt = DONE;
                        w_op_nxt    = NL;
                    end else if (w_is_shift) begin
                        w_state_nxt = IDLE;
                    end else if (w_printable) begin
                        w_state_nxt = WRITE;
                        w_op_nxt    = CHR;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = r_cursor;
                        w_data_nxt  = w_char;
                    end
                end
            end
            WRITE: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
                case (r_op)
                    CHR:     w_cursor_nxt = r_cursor + ADDR_W'(1);
                    BS:      w_cursor_nxt = r_cursor - ADDR_W'(1);
                    NL:      w_cursor_nxt = (r_cursor | COL_MASK) + ADDR_W'(1);
                    default: w_cursor_nxt = r_cursor;
                endcase
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // State, cursor and RAM port registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= CLEAR;
            r_op     <= CHR;
            r_idx    <= '0;
            r_cursor <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_idx    <= w_idx_nxt;
            r_cursor <= w_cursor_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_text_buffer_ctrl.sv
// Directed bench for ps2_text_buffer_ctrl (COLS=16, ROWS=4, DATA_W=8).
module tb_ps2_text_buffer_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_valid, key_make;
    logic [7:0] key_code, key_ascii;
    logic       we, busy, drop_tick;
    logic [5:0] write_address, cursor;
    logic [7:0] ram_in;

    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;
    int drop_count = 0;

    always #5 clk = ~clk;

    ps2_text_buffer_ctrl dut (
        .clk           (clk),
        .reset         (reset_n),
        .key_valid     (key_valid),
        .key_make      (key_make),
        .key_code      (key_code),
        .key_ascii     (key_ascii),
        .we            (we),
        .write_address (write_address),
        .ram_in        (ram_in),
        .cursor        (cursor),
        .busy          (busy),
        .drop_tick     (drop_tick)
    );

    // Count write pulses and drop pulses as seen at each clock edge.
    always @(posedge clk) begin
        if (we) we_count <= we_count + 1;
        if (drop_tick) drop_count <= drop_count + 1;
    end

    typedef struct {
        logic       make;
        logic [7:0] code;
        logic [7:0] ascii;
        logic       exp_we;
        logic [5:0] exp_addr;
        logic [7:0] exp_data;
        logic [5:0] exp_cur;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one key event for one cycle; returns in the cycle after it was sampled.
    task automatic send_key(input logic make, input logic [7:0] code, input logic [7:0] ascii);
        key_valid = 1'b1;
        key_make  = make;
        key_code  = code;
        key_ascii = ascii;
        @(negedge clk);
        key_valid = 1'b0;
        key_make  = 1'b0;
        key_code  = 8'h00;
        key_ascii = 8'h00;
    endtask

    task automatic key_op(input string name, input logic make, input logic [7:0] code,
                          input logic [7:0] ascii, input logic exp_we, input logic [5:0] exp_addr,
                          input logic [7:0] exp_data, input logic [5:0] exp_cur);
        send_key(make, code, ascii);
        chk({name, ".port"}, {we, write_address, ram_in}, {exp_we, exp_addr, exp_data});
        repeat (2) @(negedge clk);
        chk({name, ".cursor"}, {busy, cursor}, {1'b0, exp_cur});
    endtask

    // Expect a full 64-cell fill sweep starting in the current cycle.
    task automatic check_sweep(input string name);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("%s.cell%0d", name, i), {we, busy, write_address, ram_in},
                {1'b1, 1'b1, 6'(i), 8'h20});
            @(negedge clk);
        end
        chk({name, ".idle"}, {we, busy, cursor}, {1'b0, 1'b0, 6'd0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int wc0, dc0;

        vecs[0]  = '{1'b1, 8'h1C, 8'h61, 1'b1, 6'd0,  8'h61, 6'd1};
        vecs[1]  = '{1'b0, 8'h1C, 8'h61, 1'b0, 6'd0,  8'h00, 6'd1};
        vecs[2]  = '{1'b1, 8'h32, 8'h62, 1'b1, 6'd1,  8'h62, 6'd2};
        vecs[3]  = '{1'b1, 8'h5A, 8'h0D, 1'b0, 6'd0,  8'h00, 6'd16};
        vecs[4]  = '{1'b1, 8'h16, 8'h31, 1'b1, 6'd16, 8'h31, 6'd17};
        vecs[5]  = '{1'b1, 8'h66, 8'h08, 1'b1, 6'd16, 8'h20, 6'd16};
        vecs[6]  = '{1'b1, 8'h12, 8'h00, 1'b0, 6'd0,  8'h00, 6'd16};
        vecs[7]  = '{1'b0, 8'h12, 8'h00, 1'b0, 6'd0,  8'h00, 6'd16};
        vecs[8]  = '{1'b1, 8'h05, 8'h00, 1'b0, 6'd0,  8'h00, 6'd16};
        vecs[9]  = '{1'b1, 8'h71, 8'h7F, 1'b0, 6'd0,  8'h00, 6'd16};
        vecs[10] = '{1'b1, 8'h0E, 8'h7E, 1'b1, 6'd16, 8'h7E, 6'd17};
        vecs[11] = '{1'b1, 8'h29, 8'h20, 1'b1, 6'd17, 8'h20, 6'd18};
        vecs[12] = '{1'b1, 8'h5A, 8'h0D, 1'b0, 6'd0,  8'h00, 6'd32};
        vecs[13] = '{1'b1, 8'h5A, 8'h0D, 1'b0, 6'd0,  8'h00, 6'd48};
        vecs[14] = '{1'b1, 8'h5A, 8'h0D, 1'b0, 6'd0,  8'h00, 6'd0};
        vecs[15] = '{1'b1, 8'h66, 8'h08, 1'b0, 6'd0,  8'h00, 6'd0};

        // Reset state, with a key strobe that must not be reported as dropped.
        reset_n   = 1'b0;
        key_valid = 1'b1;
        key_make  = 1'b1;
        key_code  = 8'h1C;
        key_ascii = 8'h61;
        repeat (3) @(negedge clk);
        #1;
        chk("reset", {we, busy, cursor, drop_tick}, {1'b0, 1'b1, 6'd0, 1'b0});
        key_valid = 1'b0;
        key_make  = 1'b0;
        key_code  = 8'h00;
        key_ascii = 8'h00;
        reset_n   = 1'b1;
        @(negedge clk);
        check_sweep("init_clear");

        // Table of single events starting from cursor 0.
        for (int i = 0; i < 16; i++) begin
            key_op($sformatf("vec%0d", i), vecs[i].make, vecs[i].code, vecs[i].ascii,
                   vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_cur);
        end

        // Cursor wrap from the last cell.
        for (int i = 0; i < 3; i++) key_op("wrap_nl", 1'b1, 8'h5A, 8'h0D, 1'b0, 6'd0, 8'h00, 6'(16 * (i + 1)));
        for (int i = 0; i < 15; i++) key_op("wrap_fill", 1'b1, 8'h22, 8'h78, 1'b1, 6'(48 + i), 8'h78, 6'(49 + i));
        key_op("wrap_last", 1'b1, 8'h32, 8'h62, 1'b1, 6'd63, 8'h62, 6'd0);

        // Enter on the last row mid-line wraps to row 0.
        for (int i = 0; i < 3; i++) key_op("nl_setup", 1'b1, 8'h5A, 8'h0D, 1'b0, 6'd0, 8'h00, 6'(16 * (i + 1)));
        key_op("nl_c48", 1'b1, 8'h21, 8'h63, 1'b1, 6'd48, 8'h63, 6'd49);
        key_op("nl_c49", 1'b1, 8'h21, 8'h63, 1'b1, 6'd49, 8'h63, 6'd50);
        key_op("nl_from50", 1'b1, 8'h5A, 8'h0D, 1'b0, 6'd0, 8'h00, 6'd0);

        // Event arriving while busy is dropped once and never written.
        wc0 = we_count;
        dc0 = drop_count;
        send_key(1'b1, 8'h21, 8'h63);
        key_valid = 1'b1;
        key_make  = 1'b1;
        key_code  = 8'h23;
        key_ascii = 8'h64;
        #1;
        chk("drop.tick", {drop_tick, we, write_address, ram_in}, {1'b1, 1'b1, 6'd0, 8'h63});
        @(negedge clk);
        key_valid = 1'b0;
        key_make  = 1'b0;
        key_code  = 8'h00;
        key_ascii = 8'h00;
        #1;
        chk("drop.after", {drop_tick, we}, {1'b0, 1'b0});
        repeat (2) @(negedge clk);
        chk("drop.cursor", {busy, cursor}, {1'b0, 6'd1});
        chk("drop.writes", we_count - wc0, 1);
        chk("drop.pulses", drop_count - dc0, 1);

        // Escape clears the whole buffer and homes the cursor.
        send_key(1'b1, 8'h76, 8'h1B);
        chk("esc.cursor", cursor, 6'd0);
        check_sweep("esc_clear");

        // Reset in the middle of a sweep restarts it from cell 0.
        send_key(1'b1, 8'h76, 8'h1B);
        repeat (9) @(negedge clk);
        chk("midclr.pre", {we, write_address}, {1'b1, 6'd9});
        reset_n = 1'b0;
        @(negedge clk);
        chk("midclr.reset", {we, busy, cursor}, {1'b0, 1'b1, 6'd0});
        reset_n = 1'b1;
        @(negedge clk);
        check_sweep("midclr_sweep");

`ifdef PS2_TEXT_SHIFT_EN
        key_op("sh_make", 1'b1, 8'h12, 8'h00, 1'b0, 6'd0, 8'h00, 6'd0);
        key_op("sh_upper", 1'b1, 8'h1C, 8'h61, 1'b1, 6'd0, 8'h41, 6'd1);
        key_op("sh_break", 1'b0, 8'h12, 8'h00, 1'b0, 6'd0, 8'h00, 6'd1);
        key_op("sh_lower", 1'b1, 8'h1C, 8'h61, 1'b1, 6'd1, 8'h61, 6'd2);
`else
        key_op("sh_make", 1'b1, 8'h12, 8'h00, 1'b0, 6'd0, 8'h00, 6'd0);
        key_op("sh_plain", 1'b1, 8'h1C, 8'h61, 1'b1, 6'd0, 8'h61, 6'd1);
        key_op("sh_break", 1'b0, 8'h12, 8'h00, 1'b0, 6'd0, 8'h00, 6'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
